// File: rtl/permutation_sequencer_if.sv
// Handshake and state bus between the Ascon top FSM / round datapath and
// the permutation sequencer.
interface permutation_sequencer_if;
    logic         start_i;
    logic         mode_i;
    logic [319:0] state_i;
    logic [319:0] perm_state_i;
    logic [319:0] perm_state_o;
    logic [3:0]   round_o;
    logic         ready_o;
    logic         busy_o;
    logic         valid_o;
    logic [319:0] state_o;

    // Sequencer side
    modport slave (
        input  start_i, mode_i, state_i, perm_state_i,
        output perm_state_o, round_o, ready_o, busy_o, valid_o, state_o
    );

    // Controller / datapath side
    modport master (
        output start_i, mode_i, state_i, perm_state_i,
        input  perm_state_o, round_o, ready_o, busy_o, valid_o, state_o
    );
endinterface

// File: rtl/permutation_sequencer.sv
// Iterative round controller for the Ascon permutation: holds the 320-bit
// state, steps the round index through 12-N..11 and captures one round of
// the external combinational datapath per cycle.
module permutation_sequencer #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    permutation_sequencer_if.slave  seq_if
);

    // Round counts outside 1..12 would start the counter outside 0..11.
    if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_rounds_a
        $error("permutation_sequencer: ROUNDS_A must be in 1..12");
    end
    if (ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_rounds_b
        $error("permutation_sequencer: ROUNDS_B must be in 1..12");
    end

    localparam logic [3:0] FIRST_A    = 4'(12 - ROUNDS_A);
    localparam logic [3:0] FIRST_B    = 4'(12 - ROUNDS_B);
    localparam logic [3:0] LAST_ROUND = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       r_fsm;
    logic [319:0] r_state;
    logic [3:0]   r_round;
    logic         r_ready;
    logic         r_busy;
    logic         r_valid;
    logic [3:0]   w_first_round;

    // First round index of the requested permutation variant.
    assign w_first_round = seq_if.mode_i ? FIRST_B : FIRST_A;

    // Round FSM: owns state register, round counter and registered status flags.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_fsm   <= IDLE;
            r_state <= '0;
            r_round <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (seq_if.start_i) begin
                        r_state <= seq_if.state_i;
                        r_round <= w_first_round;
                        r_fsm   <= RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    r_state <= seq_if.perm_state_i;
                    if (r_round == LAST_ROUND) begin
                        r_fsm   <= DONE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                DONE: begin
                    r_fsm   <= IDLE;
                    r_round <= '0;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_fsm   <= IDLE;
                    r_round <= '0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // The counter saturates at 11 by construction; 12..15 indicate corruption.
    a_round_range: assert property (@(posedge clock_i) disable iff (reset_i)
        r_round <= LAST_ROUND)
        else $error("permutation_sequencer: round counter out of range");

    assign seq_if.perm_state_o = r_state;
    assign seq_if.state_o      = r_state;
    assign seq_if.round_o      = r_round;
    assign seq_if.ready_o      = r_ready;
    assign seq_if.busy_o       = r_busy;
    assign seq_if.valid_o      = r_valid;

endmodule
